// File: rtl/pulse_height_analyzer_if.sv
// rtl/pulse_height_analyzer_if.sv - event readout handshake between analyzer and histogram logic
//
// Signals:
//   event_valid   master->slave  head event present
//   event_ready   slave->master  consumer accepts head event
//   event_amp     master->slave  signed peak amplitude
//   event_time    master->slave  timestamp of the peak sample
//   event_width   master->slave  cycles above threshold (saturating)
//   event_pileup  master->slave  width exceeded the pile-up limit
interface pulse_height_analyzer_if #(
    parameter int DATA_W  = 16,
    parameter int TS_W    = 32,
    parameter int WIDTH_W = 8
);
    logic                      event_valid;
    logic                      event_ready;
    logic signed [DATA_W-1:0]  event_amp;
    logic        [TS_W-1:0]    event_time;
    logic        [WIDTH_W-1:0] event_width;
    logic                      event_pileup;

    modport master (
        output event_valid,
        output event_amp,
        output event_time,
        output event_width,
        output event_pileup,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_amp,
        input  event_time,
        input  event_width,
        input  event_pileup,
        output event_ready
    );
endinterface

// File: rtl/pulse_height_analyzer.sv
// rtl/pulse_height_analyzer.sv - threshold pulse detector with peak/time/width capture and event FIFO
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-low
//   i_filter_data  in   signed shaped sample, one per clock
//   i_threshold    in   signed trigger level, compared every cycle
//   m_evt          --   event readout handshake (master side)
//   o_drop_count   out  events lost to a full queue, saturating
module pulse_height_analyzer #(
    parameter int DATA_W     = 16,
    parameter int TS_W       = 32,
    parameter int WIDTH_W    = 8,
    parameter int MAX_WIDTH  = 64,
    parameter int HOLDOFF    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] i_filter_data,
    input  logic signed [DATA_W-1:0] i_threshold,
    pulse_height_analyzer_if.master  m_evt,
    output logic        [DROP_W-1:0] o_drop_count
);
    localparam int          PTR_W        = $clog2(FIFO_DEPTH);
    localparam int          HOLD_W       = $clog2(HOLDOFF + 2);
    localparam int          ENTRY_W      = DATA_W + TS_W + WIDTH_W + 1;
    localparam logic [31:0] LP_MAX_WIDTH = MAX_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABOVE,
        ST_HOLD
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic        [TS_W-1:0]    r_ts;
    logic signed [DATA_W-1:0]  r_peak;
    logic signed [DATA_W-1:0]  w_peak_nxt;
    logic        [TS_W-1:0]    r_peak_ts;
    logic        [TS_W-1:0]    w_peak_ts_nxt;
    logic        [WIDTH_W-1:0] r_width;
    logic        [WIDTH_W-1:0] w_width_nxt;
    logic        [HOLD_W-1:0]  r_hold_cnt;
    logic        [HOLD_W-1:0]  w_hold_cnt_nxt;
    logic                      w_above;
    logic                      w_push;
    logic                      w_pileup;

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [DROP_W-1:0]  r_drop_count;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    assign w_above  = i_filter_data > i_threshold;
    assign w_pileup = {{(32-WIDTH_W){1'b0}}, r_width} > LP_MAX_WIDTH;

    always_comb begin
        w_state_nxt    = r_state;
        w_peak_nxt     = r_peak;
        w_peak_ts_nxt  = r_peak_ts;
        w_width_nxt    = r_width;
        w_hold_cnt_nxt = r_hold_cnt;
        w_push         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_above) begin
                    w_state_nxt   = ST_ABOVE;
                    w_peak_nxt    = i_filter_data;
                    w_peak_ts_nxt = r_ts;
                    w_width_nxt   = WIDTH_W'(1);
                end
            end
            ST_ABOVE: begin
                if (w_above) begin
                    if (r_width != '1) begin
                        w_width_nxt = r_width + WIDTH_W'(1);
                    end
                    // strict compare: a plateau keeps the timestamp of its first sample
                    if (i_filter_data > r_peak) begin
                        w_peak_nxt    = i_filter_data;
                        w_peak_ts_nxt = r_ts;
                    end
                end else begin
                    w_push = 1'b1;
                    if (HOLDOFF == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt    = ST_HOLD;
                        w_hold_cnt_nxt = HOLD_W'(HOLDOFF - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ts       <= '0;
            r_peak     <= '0;
            r_peak_ts  <= '0;
            r_width    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ts       <= r_ts + TS_W'(1);
            r_peak     <= w_peak_nxt;
            r_peak_ts  <= w_peak_ts_nxt;
            r_width    <= w_width_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Event queue: pointers carry one wrap bit to tell full from empty.
    assign w_empty = r_wr_ptr == r_rd_ptr;
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && m_evt.event_ready;
    // a pop on the same edge frees the slot the push needs
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_peak, r_peak_ts, r_width, w_pileup};
        end
    end

    // Head is gated with empty so stale entries never reach the outputs.
    assign w_head             = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    assign m_evt.event_valid  = !w_empty;
    assign m_evt.event_amp    = w_head[ENTRY_W-1 -: DATA_W];
    assign m_evt.event_time   = w_head[WIDTH_W+TS_W : WIDTH_W+1];
    assign m_evt.event_width  = w_head[WIDTH_W:1];
    assign m_evt.event_pileup = w_head[0];
    assign o_drop_count       = r_drop_count;
endmodule

// File: tb/tb_pulse_height_analyzer.sv
// tb/tb_pulse_height_analyzer.sv - directed self-checking bench for pulse_height_analyzer
module tb_pulse_height_analyzer;
    logic               clk;
    logic               reset;
    logic signed [15:0] filter_data;
    logic signed [15:0] threshold;
    logic        [15:0] drop_count;
    int                 checks;
    int                 failures;
    int                 cyc;
    int                 t_exp [6];
    int                 t_one;
    int                 spurious;

    pulse_height_analyzer_if #(.DATA_W(16), .TS_W(32), .WIDTH_W(8)) evt_if ();

    pulse_height_analyzer #(
        .DATA_W(16), .TS_W(32), .WIDTH_W(8), .MAX_WIDTH(64),
        .HOLDOFF(16), .FIFO_DEPTH(4), .DROP_W(16)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_filter_data(filter_data),
        .i_threshold  (threshold),
        .m_evt        (evt_if.master),
        .o_drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic signed [15:0] s);
        filter_data = s;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        evt_if.event_ready = 1'b0;
        filter_data = '0;
        tick();
        tick();
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic pop_one();
        evt_if.event_ready = 1'b1;
        tick();
        evt_if.event_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (evt_if.event_valid !== 1'b0 || evt_if.event_amp !== 16'sd0 || evt_if.event_time !== 32'd0 ||
            evt_if.event_width !== 8'd0 || evt_if.event_pileup !== 1'b0 || drop_count !== 16'd0) begin
            $display("FAIL reset_state got valid=%0b amp=%0d time=%0d width=%0d pileup=%0b drop=%0d exp all zero",
                     evt_if.event_valid, evt_if.event_amp, evt_if.event_time, evt_if.event_width,
                     evt_if.event_pileup, drop_count);
            failures++;
        end
    endtask

    task automatic test_basic();
        threshold = 16'sd100;
        do_reset();
        repeat (10) drive(16'sd0);
        drive(16'sd0);
        drive(16'sd150);
        drive(16'sd300);
        drive(16'sd250);
        checks++;
        if (evt_if.event_valid !== 1'b0) begin
            $display("FAIL basic_valid_early got=%0b exp=0", evt_if.event_valid);
            failures++;
        end
        drive(16'sd90);
        checks++;
        if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'sd300 || evt_if.event_time !== 32'd12 ||
            evt_if.event_width !== 8'd3 || evt_if.event_pileup !== 1'b0) begin
            $display("FAIL basic_event got valid=%0b amp=%0d time=%0d width=%0d pileup=%0b exp 1/300/12/3/0",
                     evt_if.event_valid, evt_if.event_amp, evt_if.event_time, evt_if.event_width, evt_if.event_pileup);
            failures++;
        end
        pop_one();
        checks++;
        if (evt_if.event_valid !== 1'b0) begin
            $display("FAIL basic_pop got valid=%0b exp=0", evt_if.event_valid);
            failures++;
        end
    endtask

    task automatic test_plateau();
        threshold = 16'sd100;
        do_reset();
        drive(16'sd0);
        drive(16'sd200);
        drive(16'sd400);
        drive(16'sd400);
        drive(16'sd50);
        checks++;
        if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'sd400 ||
            evt_if.event_time !== 32'd2 || evt_if.event_width !== 8'd3) begin
            $display("FAIL plateau_event got valid=%0b amp=%0d time=%0d width=%0d exp 1/400/2/3",
                     evt_if.event_valid, evt_if.event_amp, evt_if.event_time, evt_if.event_width);
            failures++;
        end
        filter_data = 16'sd0;
        pop_one();
        repeat (14) drive(16'sd0);
        drive(16'sd500);
        drive(16'sd600);
        checks++;
        if (evt_if.event_valid !== 1'b0) begin
            $display("FAIL holdoff_no_event got valid=%0b exp=0", evt_if.event_valid);
            failures++;
        end
        drive(16'sd0);
        checks++;
        if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'sd600 ||
            evt_if.event_time !== 32'd21 || evt_if.event_width !== 8'd1) begin
            $display("FAIL holdoff_event got valid=%0b amp=%0d time=%0d width=%0d exp 1/600/21/1",
                     evt_if.event_valid, evt_if.event_amp, evt_if.event_time, evt_if.event_width);
            failures++;
        end
        pop_one();
    endtask

    task automatic test_pileup();
        int lens [4] = '{70, 64, 65, 300};
        int wexp [4] = '{70, 64, 65, 255};
        int pexp [4] = '{1, 0, 1, 1};
        threshold = 16'sd100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            repeat (20) drive(16'sd0);
            t_one = cyc;
            repeat (lens[i]) drive(16'sd500);
            drive(16'sd0);
            checks++;
            if (evt_if.event_valid !== 1'b1 || evt_if.event_width !== 8'(wexp[i]) ||
                evt_if.event_pileup !== 1'(pexp[i]) || evt_if.event_time !== 32'(t_one)) begin
                $display("FAIL pileup_len%0d got valid=%0b width=%0d pileup=%0b time=%0d exp width=%0d pileup=%0d time=%0d",
                         lens[i], evt_if.event_valid, evt_if.event_width, evt_if.event_pileup, evt_if.event_time,
                         wexp[i], pexp[i], t_one);
                failures++;
            end
            pop_one();
        end
    endtask

    task automatic test_back_to_back();
        threshold = 16'sd100;
        do_reset();
        drive(16'sd0);
        for (int k = 0; k < 6; k++) begin
            t_exp[k] = cyc;
            drive(16'(200 + 10 * k));
            drive(16'sd0);
            checks++;
            if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'sd200 || evt_if.event_time !== 32'(t_exp[0])) begin
                $display("FAIL head_stable_%0d got valid=%0b amp=%0d time=%0d exp 1/200/%0d",
                         k, evt_if.event_valid, evt_if.event_amp, evt_if.event_time, t_exp[0]);
                failures++;
            end
            repeat (16) drive(16'sd0);
        end
        checks++;
        if (drop_count !== 16'd2) begin
            $display("FAIL drop_count got=%0d exp=2", drop_count);
            failures++;
        end
        evt_if.event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'(200 + 10 * i) ||
                evt_if.event_time !== 32'(t_exp[i])) begin
                $display("FAIL drain_%0d got valid=%0b amp=%0d time=%0d exp 1/%0d/%0d",
                         i, evt_if.event_valid, evt_if.event_amp, evt_if.event_time, 200 + 10 * i, t_exp[i]);
                failures++;
            end
            tick();
        end
        evt_if.event_ready = 1'b0;
        checks++;
        if (evt_if.event_valid !== 1'b0) begin
            $display("FAIL drain_empty got valid=%0b exp=0", evt_if.event_valid);
            failures++;
        end
    endtask

    task automatic test_push_pop_full();
        threshold = 16'sd100;
        do_reset();
        drive(16'sd0);
        for (int k = 0; k < 4; k++) begin
            t_exp[k] = cyc;
            drive(16'(300 + 10 * k));
            drive(16'sd0);
            repeat (16) drive(16'sd0);
        end
        t_exp[4] = cyc;
        drive(16'sd340);
        evt_if.event_ready = 1'b1;
        drive(16'sd0);
        evt_if.event_ready = 1'b0;
        checks++;
        if (drop_count !== 16'd0 || evt_if.event_amp !== 16'sd310) begin
            $display("FAIL full_pushpop got drop=%0d head=%0d exp drop=0 head=310", drop_count, evt_if.event_amp);
            failures++;
        end
        evt_if.event_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'(300 + 10 * i) ||
                evt_if.event_time !== 32'(t_exp[i])) begin
                $display("FAIL full_drain_%0d got valid=%0b amp=%0d time=%0d exp 1/%0d/%0d",
                         i, evt_if.event_valid, evt_if.event_amp, evt_if.event_time, 300 + 10 * i, t_exp[i]);
                failures++;
            end
            tick();
        end
        evt_if.event_ready = 1'b0;
    endtask

    task automatic test_negative();
        threshold = -16'sd50;
        do_reset();
        drive(-16'sd100);
        drive(-16'sd20);
        drive(-16'sd60);
        checks++;
        if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== -16'sd20 ||
            evt_if.event_width !== 8'd1 || evt_if.event_time !== 32'd1) begin
            $display("FAIL negative got valid=%0b amp=%0d width=%0d time=%0d exp 1/-20/1/1",
                     evt_if.event_valid, evt_if.event_amp, evt_if.event_width, evt_if.event_time);
            failures++;
        end
        pop_one();
    endtask

    task automatic test_reset_mid();
        threshold = 16'sd100;
        do_reset();
        drive(16'sd0);
        for (int k = 0; k < 2; k++) begin
            drive(16'(400 + 10 * k));
            drive(16'sd0);
            repeat (16) drive(16'sd0);
        end
        drive(16'sd500);
        drive(16'sd500);
        checks++;
        if (evt_if.event_valid !== 1'b1) begin
            $display("FAIL pre_reset_queue got valid=%0b exp=1", evt_if.event_valid);
            failures++;
        end
        reset = 1'b0;
        tick();
        checks++;
        if (evt_if.event_valid !== 1'b0 || drop_count !== 16'd0 || evt_if.event_amp !== 16'sd0) begin
            $display("FAIL mid_reset got valid=%0b drop=%0d amp=%0d exp 0/0/0",
                     evt_if.event_valid, drop_count, evt_if.event_amp);
            failures++;
        end
        reset = 1'b1;
        cyc = 0;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            drive(16'sd0);
            if (evt_if.event_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            $display("FAIL post_reset_spurious got=%0d exp=0", spurious);
            failures++;
        end
        t_one = cyc;
        drive(16'sd450);
        drive(16'sd0);
        checks++;
        if (evt_if.event_valid !== 1'b1 || evt_if.event_amp !== 16'sd450 || evt_if.event_time !== 32'(t_one)) begin
            $display("FAIL post_reset_ts got valid=%0b amp=%0d time=%0d exp 1/450/%0d",
                     evt_if.event_valid, evt_if.event_amp, evt_if.event_time, t_one);
            failures++;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        reset = 1'b0;
        filter_data = '0;
        threshold = 16'sd100;
        evt_if.event_ready = 1'b0;
        test_reset();
        test_basic();
        test_plateau();
        test_pileup();
        test_back_to_back();
        test_push_pop_full();
        test_negative();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
